// File: rtl/controle_rolhas.sv
// Purpose : corking-station sequencer; drives the cork down-counter and the actuator, halts the line on empty stock.
// Latency : Moore outputs are registered and change on the same edge as the state they belong to.
// Backpres: none; the conveyor is stopped while a bottle is sealed, the stock is empty or a fault is pending.
//
// Ports:
//   CLOCK, RESET_N           rising-edge clock, asynchronous active-low reset
//   SENSOR_GARRAFA           bottle present at the station
//   CORK_DONE                actuator reports the cork is in
//   REFILL_REQ, CLEAR_FAULT  operator refill button and fault acknowledge
//   COUNT, ZERO              cork stock and zero flag from the external counter
//   CNT_ENABLE/LOAD/DADOS    decrement strobe, load strobe and load value for that counter
//   ACTUATOR_GO, CONVEYOR_RUN actuator command and conveyor motor enable
//   ALARM_EMPTY, ALARM_LOW, FAULT  status flags
//   SEALED_COUNT             bottles sealed since reset (wraps)
module controle_rolhas #(
  parameter int REFILL_QTY  = 99,
  parameter int LOW_THRESH  = 10,
  parameter int TIMEOUT_CYC = 1000,
  parameter int TIMER_W     = 16
) (
  input  logic        CLOCK,
  input  logic        RESET_N,
  input  logic        SENSOR_GARRAFA,
  input  logic        CORK_DONE,
  input  logic        REFILL_REQ,
  input  logic        CLEAR_FAULT,
  input  logic [6:0]  COUNT,
  input  logic        ZERO,
  output logic        CNT_ENABLE,
  output logic        CNT_LOAD,
  output logic [6:0]  CNT_DADOS,
  output logic        ACTUATOR_GO,
  output logic        CONVEYOR_RUN,
  output logic        ALARM_EMPTY,
  output logic        ALARM_LOW,
  output logic        FAULT,
  output logic [15:0] SEALED_COUNT
);

  localparam logic [TIMER_W-1:0] timer_last = TIMER_W'(TIMEOUT_CYC - 1);
  localparam logic [6:0]         refill_val = 7'(REFILL_QTY);
  localparam logic [6:0]         low_val    = 7'(LOW_THRESH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEAL,
    S_DECR,
    S_RELEASE,
    S_EMPTY,
    S_LOAD,
    S_WAITREL,
    S_FAULT
  } state_t;

  // Registered Moore outputs kept together so they reset and update as one word.
  typedef struct packed {
    logic cnt_enable;
    logic cnt_load;
    logic actuator_go;
    logic conveyor_run;
    logic alarm_empty;
    logic fault;
  } outs_t;

  state_t             state_q, state_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  outs_t              outs_q, outs_d;
  logic               alarm_low_q;
  logic [15:0]        sealed_q;

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    case (state_q)
      S_IDLE: begin
        if (ZERO) begin
          state_d = S_EMPTY;
        end else if (REFILL_REQ) begin
          state_d = S_LOAD;
        end else if (SENSOR_GARRAFA) begin
          state_d = S_SEAL;
          timer_d = '0;   // every seal starts a fresh timeout window
        end
      end
      S_SEAL: begin
        // A confirmation arriving on the last allowed cycle still counts as a seal.
        if (CORK_DONE) begin
          state_d = S_DECR;
        end else if (timer_q == timer_last) begin
          state_d = S_FAULT;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      S_DECR:    state_d = S_RELEASE;
      // Wait for the bottle to leave so a held sensor cannot trigger a second seal.
      S_RELEASE: if (!SENSOR_GARRAFA) state_d = S_IDLE;
      S_EMPTY:   if (REFILL_REQ) state_d = S_LOAD;
      S_LOAD:    state_d = S_WAITREL;
      // One load per button press: the button must be released first.
      S_WAITREL: if (!REFILL_REQ) state_d = S_IDLE;
      S_FAULT:   if (CLEAR_FAULT) state_d = S_RELEASE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Outputs decoded from the next state so they are registered alongside it.
  always_comb begin
    outs_d = '0;
    case (state_d)
      S_IDLE:    outs_d.conveyor_run = 1'b1;
      S_SEAL:    outs_d.actuator_go  = 1'b1;
      S_DECR:    outs_d.cnt_enable   = !ZERO;   // never decrement an empty counter
      S_RELEASE: outs_d.conveyor_run = 1'b1;
      S_EMPTY:   outs_d.alarm_empty  = 1'b1;
      S_LOAD:    outs_d.cnt_load     = 1'b1;
      S_FAULT:   outs_d.fault        = 1'b1;
      default:   outs_d = '0;
    endcase
  end

  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q     <= S_IDLE;
      timer_q     <= '0;
      outs_q      <= '0;
      alarm_low_q <= 1'b0;
      sealed_q    <= '0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      outs_q      <= outs_d;
      alarm_low_q <= (COUNT != 7'd0) && (COUNT <= low_val);
      if (state_q == S_SEAL && state_d == S_DECR) begin
        sealed_q <= sealed_q + 16'd1;
      end
    end
  end

  assign CNT_ENABLE   = outs_q.cnt_enable;
  assign CNT_LOAD     = outs_q.cnt_load;
  assign CNT_DADOS    = refill_val;
  assign ACTUATOR_GO  = outs_q.actuator_go;
  assign CONVEYOR_RUN = outs_q.conveyor_run;
  assign ALARM_EMPTY  = outs_q.alarm_empty;
  assign ALARM_LOW    = alarm_low_q;
  assign FAULT        = outs_q.fault;
  assign SEALED_COUNT = sealed_q;

endmodule
